synapse_frame_builder: RTL and testbench
========================================

// Module: synapse_frame_builder
// PURPOSE
//   Producer side of the synapse summation interface. Accepts a narrow valid/ready beat stream
//   of per-synapse {spike, weight} pairs and assembles one full frame of 2-bit gated terms
//   (term = spike ? weight : 2'b00). Presents the frame as the packed wx vector consumed by
//   the adder tree. Double-buffered: one frame is assembled while the previous one is held.
// PARAMETERS
//   n_stage     5  tree depth; frame = 2**n_stage terms, wx width = 2**(n_stage+1) bits
//   BEAT_TERMS  4  terms per input beat; power of 2, 1..2**n_stage
//   (derived) N_BEATS = 2**n_stage / BEAT_TERMS beats per frame (8 at defaults)
// PORTS
//   clk        in   1                   clock; all state updates on the rising edge
//   rst_n      in   1                   asynchronous active-low reset
//   in_valid   in   1                   beat valid
//   in_ready   out  1                   beat ready; a beat transfers when in_valid & in_ready
//   in_spike   in   BEAT_TERMS          spike bit per term; bit i -> term i of the beat
//   in_weight  in   2*BEAT_TERMS        weights; [2i+1:2i] -> term i of the beat
//   in_last    in   1                   marks the final beat of a frame
//   wx_out     out  2**(n_stage+1)      frame; term t occupies bits [2t+1:2t]
//   wx_valid   out  1                   frame valid
//   wx_ready   in   1                   frame consumed when wx_valid & wx_ready
//   frame_err  out  1                   one-cycle pulse on a framing error
// BEHAVIOUR
//   Reset (async assert, sync release): wx_out=0, wx_valid=0, frame_err=0, beat_cnt=0,
//     assembly register=0, state=FILL; in_ready=1 in the first cycle after release.
//   Term placement: beat k (k = beat_cnt) writes terms k*BEAT_TERMS .. k*BEAT_TERMS+BEAT_TERMS-1;
//     term i of the beat lands at index k*BEAT_TERMS+i. Gating is done on accept, not on output.
//   States: FILL (in_ready=1), HOLD (in_ready=0; complete frame waiting for the output slot).
//   FILL, beat accepted, beat_cnt < N_BEATS-1, in_last=0: write terms, beat_cnt++.
//   FILL, beat accepted, beat_cnt == N_BEATS-1, in_last=1: frame complete; beat_cnt=0.
//     If the output slot is free (wx_valid=0, or wx_valid & wx_ready in this cycle), the
//     completed frame (including this beat) loads wx_out and wx_valid=1 next cycle; stay in FILL.
//     Otherwise stay with the frame in the assembly register and go to HOLD.
//   HOLD: when the output slot frees (wx_valid & wx_ready), load wx_out from the assembly
//     register and keep wx_valid=1; go to FILL next cycle (in_ready=1 one cycle after the pop).
//   Framing error: accepted beat with in_last=1 and beat_cnt < N_BEATS-1 (short frame), or
//     in_last=0 and beat_cnt == N_BEATS-1 (long frame): drop the partial frame, clear the
//     assembly register, beat_cnt=0, pulse frame_err the next cycle; wx_out/wx_valid unaffected.
//   Output: wx_out and wx_valid are registered; wx_out is stable while wx_valid & !wx_ready.
//     wx_valid falls the cycle after a pop unless a new frame loads in the same cycle.
//   Latency: last beat accepted at cycle T with free slot -> wx_valid=1 at T+1.
//   Throughput: one frame per N_BEATS cycles when wx_ready is held high (no bubbles).
//   No combinational path from wx_ready or in_valid to in_ready (in_ready = state==FILL).
//   Reset mid-frame: partial frame and held frame are discarded; no frame_err pulse.
//   N_BEATS == 1: every accepted beat must carry in_last=1; otherwise frame_err.
// TESTING
//   1 Reset: rst_n low mid-run -> wx_valid=0, wx_out=0, in_ready=1 after release, no frame_err.
//   2 Defaults, wx_ready=1: 8 beats, beat k spikes=4'b1111, weights all 2'(k%4), last on k=7
//     -> wx_valid at T+1, term t = (t/4)%4, consuming adder tree sum = 48; next frame back-to-back.
//   3 Gating: spikes=4'b0101, weights=8'hFF every beat -> term t = 3 for even t, 0 for odd t.
//   4 Backpressure: wx_ready=0, send 2 full frames -> frame 1 held stable on wx_out, in_ready=0
//     after frame 2 completes (HOLD); raise wx_ready 1 cycle -> frame 2 on wx_out, in_ready=1 next.
//   5 Short frame: in_last on beat 3 -> frame_err 1 cycle, no wx_valid; next 8-beat frame correct.
//   6 Long frame: no in_last on beat 7 -> frame_err, frame dropped; following frame assembles
//     from term 0; random valid/ready stall stress vs. reference model, 1000 frames, no mismatch.

Source files
------------

// File: rtl/synapse_frame_builder.sv
// Producer side of the synapse summation interface: packs {spike, weight} beats into
// a frame of 2-bit gated terms, double-buffered against the adder-tree consumer.
module synapse_frame_builder #(
  parameter int unsigned n_stage    = 5,
  parameter int unsigned BEAT_TERMS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BEAT_TERMS-1:0]         in_spike,
  input  logic [2*BEAT_TERMS-1:0]       in_weight,
  input  logic                          in_last,
  output logic [2**(n_stage+1)-1:0]     wx_out,
  output logic                          wx_valid,
  input  logic                          wx_ready,
  output logic                          frame_err
);

  localparam int unsigned N_TERMS = 2 ** n_stage;
  localparam int unsigned WX_W    = 2 * N_TERMS;
  localparam int unsigned BEAT_W  = 2 * BEAT_TERMS;
  localparam int unsigned N_BEATS = N_TERMS / BEAT_TERMS;
  localparam int unsigned CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [WX_W-1:0]  asm_q, asm_d;
  logic [WX_W-1:0]  wx_out_q, wx_out_d;
  logic             wx_valid_q, wx_valid_d;
  logic             frame_err_q, frame_err_d;

  logic [BEAT_W-1:0] beat_terms;
  logic [WX_W-1:0]   asm_merged;
  logic              accept;
  logic              pop;
  logic              slot_free;
  logic              at_last;

  // Gating happens here, on accept, so the held frame is already in term form.
  always_comb begin
    beat_terms = '0;
    for (int i = 0; i < int'(BEAT_TERMS); i++) begin
      beat_terms[2*i +: 2] = in_spike[i] ? in_weight[2*i +: 2] : 2'b00;
    end
  end

  always_comb begin
    asm_merged = asm_q;
    for (int k = 0; k < int'(N_BEATS); k++) begin
      if (beat_cnt_q == CNT_W'(k)) begin
        asm_merged[k*BEAT_W +: BEAT_W] = beat_terms;
      end
    end
  end

  assign in_ready  = (state_q == FILL);
  assign accept    = in_valid & in_ready;
  assign pop       = wx_valid_q & wx_ready;
  assign slot_free = ~wx_valid_q | wx_ready;
  assign at_last   = (beat_cnt_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    asm_d       = asm_q;
    wx_out_d    = wx_out_q;
    wx_valid_d  = wx_valid_q;
    frame_err_d = 1'b0;

    if (pop) begin
      wx_valid_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (accept) begin
          if (in_last && at_last) begin
            beat_cnt_d = '0;
            if (slot_free) begin
              wx_out_d   = asm_merged;
              wx_valid_d = 1'b1;
              asm_d      = '0;
            end else begin
              asm_d   = asm_merged;
              state_d = HOLD;
            end
          end else if (in_last || at_last) begin
            // Short or long frame: discard everything gathered so far.
            asm_d       = '0;
            beat_cnt_d  = '0;
            frame_err_d = 1'b1;
          end else begin
            asm_d      = asm_merged;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (pop) begin
          wx_out_d   = asm_q;
          wx_valid_d = 1'b1;
          asm_d      = '0;
          state_d    = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      beat_cnt_q  <= '0;
      asm_q       <= '0;
      wx_out_q    <= '0;
      wx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      asm_q       <= asm_d;
      wx_out_q    <= wx_out_d;
      wx_valid_q  <= wx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wx_out    = wx_out_q;
  assign wx_valid  = wx_valid_q;
  assign frame_err = frame_err_q;

`ifndef SYNTHESIS
  a_wx_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (wx_valid && !wx_ready) |=> (wx_valid && $stable(wx_out)));
  a_hold_has_output: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == HOLD) |-> wx_valid);
`endif

endmodule

// File: tb/tb_synapse_frame_builder.sv
// Bench for synapse_frame_builder: directed vector table, hand-written backpressure/reset
// sequences and randomized stress against a frame-queue reference model.
module tb_synapse_frame_builder;

  localparam int NT = 32;
  localparam int BT = 4;
  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_spike = '0;
  logic [7:0]  in_weight = '0;
  logic        in_last = 1'b0;
  logic [63:0] wx_out;
  logic        wx_valid;
  logic        wx_ready = 1'b0;
  logic        frame_err;

  synapse_frame_builder #(
    .n_stage   (5),
    .BEAT_TERMS(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_spike (in_spike),
    .in_weight(in_weight),
    .in_last  (in_last),
    .wx_out   (wx_out),
    .wx_valid (wx_valid),
    .wx_ready (wx_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Expected term t of a frame, straight from the pattern definitions.
  function automatic logic [1:0] exp_term(input int kind, input int t);
    case (kind)
      0:       return 2'((t / 4) % 4);
      1:       return (t % 2 == 0) ? 2'd3 : 2'd0;
      default: return 2'(3 - (t / 4) % 4);
    endcase
  endfunction

  function automatic logic [63:0] exp_frame(input int kind);
    logic [63:0] f = '0;
    for (int t = 0; t < NT; t++) f[2*t +: 2] = exp_term(kind, t);
    return f;
  endfunction

  function automatic int sum_terms(input logic [63:0] f);
    int s = 0;
    for (int t = 0; t < NT; t++) s += int'(f[2*t +: 2]);
    return s;
  endfunction

  function automatic logic [3:0] beat_spike(input int kind);
    return (kind == 1) ? 4'b0101 : 4'b1111;
  endfunction

  function automatic logic [7:0] beat_weight(input int kind, input int k);
    logic [1:0] w;
    case (kind)
      0:       w = 2'(k % 4);
      1:       w = 2'd3;
      default: w = 2'(3 - k % 4);
    endcase
    return {w, w, w, w};
  endfunction

  typedef struct {
    logic [3:0]  spike;
    logic [7:0]  weight;
    logic        last;
    logic        exp_valid;
    logic        exp_err;
    logic        chk_wx;
    logic [63:0] exp_wx;
    int          exp_sum;
  } vec_t;

  vec_t vecs[$];

  // wx_ready stays high during the table, so every frame is popped the cycle it appears.
  task automatic add_frame(input int kind, input int nbeats, input int last_at);
    vec_t v;
    for (int k = 0; k < nbeats; k++) begin
      v.spike     = beat_spike(kind);
      v.weight    = beat_weight(kind, k);
      v.last      = (k == last_at);
      v.exp_valid = (k == NB - 1) && (last_at == NB - 1);
      v.exp_err   = ((k == last_at) && (k != NB - 1)) || ((k == NB - 1) && (last_at != NB - 1));
      v.chk_wx    = v.exp_valid;
      v.exp_wx    = exp_frame(kind);
      v.exp_sum   = (kind == 0) ? 48 : sum_terms(exp_frame(kind));
      vecs.push_back(v);
    end
  endtask

  task automatic send_frame(input int kind);
    for (int k = 0; k < NB; k++) begin
      check("beat_in_ready", 64'(in_ready), 64'(1));
      in_valid  = 1'b1;
      in_spike  = beat_spike(kind);
      in_weight = beat_weight(kind, k);
      in_last   = (k == NB - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference model state for the stress phase.
  logic [63:0] mq[$];
  logic [1:0]  terms[$];
  logic        err_exp;
  int          frames_done;
  int          cycles;

  initial begin
    logic v, r, l, acc, pop;
    logic [3:0] sp;
    logic [7:0] w;
    logic [63:0] f;
    int roll;

    // Power-on reset
    repeat (2) @(negedge clk);
    check("rst_wx_valid", 64'(wx_valid), 64'(0));
    check("rst_wx_out", wx_out, 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed table: normal, back-to-back, gating, short, recovery, long, recovery
    add_frame(0, 8, 7);
    add_frame(0, 8, 7);
    add_frame(1, 8, 7);
    add_frame(0, 4, 3);
    add_frame(0, 8, 7);
    add_frame(0, 8, -1);
    add_frame(2, 8, 7);
    wx_ready = 1'b1;
    foreach (vecs[i]) begin
      in_valid  = 1'b1;
      in_spike  = vecs[i].spike;
      in_weight = vecs[i].weight;
      in_last   = vecs[i].last;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 64'(wx_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_err", i), 64'(frame_err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(1));
      if (vecs[i].chk_wx) begin
        check($sformatf("vec%0d_wx", i), wx_out, vecs[i].exp_wx);
        check($sformatf("vec%0d_sum", i), 64'(sum_terms(wx_out)), 64'(vecs[i].exp_sum));
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("drain_valid", 64'(wx_valid), 64'(0));

    // Backpressure: two frames against a stalled consumer
    wx_ready = 1'b0;
    send_frame(0);
    check("bp_f1_valid", 64'(wx_valid), 64'(1));
    check("bp_f1_wx", wx_out, exp_frame(0));
    send_frame(1);
    check("bp_hold_ready", 64'(in_ready), 64'(0));
    check("bp_hold_wx", wx_out, exp_frame(0));
    in_valid  = 1'b1;
    in_spike  = 4'hF;
    in_weight = 8'hAA;
    in_last   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_ready", 64'(in_ready), 64'(0));
      check("bp_stall_wx", wx_out, exp_frame(0));
      check("bp_stall_valid", 64'(wx_valid), 64'(1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wx_ready = 1'b1;
    @(negedge clk);
    wx_ready = 1'b0;
    check("bp_f2_wx", wx_out, exp_frame(1));
    check("bp_f2_valid", 64'(wx_valid), 64'(1));
    check("bp_f2_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    check("bp_f2_stable", wx_out, exp_frame(1));
    wx_ready = 1'b1;
    @(negedge clk);
    check("bp_drained", 64'(wx_valid), 64'(0));

    // Reset mid-run with a held frame and a partial frame in flight
    wx_ready = 1'b0;
    send_frame(2);
    for (int k = 0; k < 3; k++) begin
      in_valid  = 1'b1;
      in_spike  = 4'hF;
      in_weight = beat_weight(0, k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(wx_valid), 64'(0));
    check("mid_rst_wx", wx_out, 64'(0));
    check("mid_rst_err", 64'(frame_err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 64'(in_ready), 64'(1));
    check("mid_rst_err2", 64'(frame_err), 64'(0));
    wx_ready = 1'b1;
    send_frame(1);
    check("post_rst_valid", 64'(wx_valid), 64'(1));
    check("post_rst_wx", wx_out, exp_frame(1));
    check("post_rst_err", 64'(frame_err), 64'(0));

    // Randomized stress against the frame-queue model
    in_valid = 1'b0;
    wx_ready = 1'b0;
    do_reset();
    err_exp     = 1'b0;
    frames_done = 0;
    cycles      = 0;
    while (frames_done < 1000 && cycles < 40000) begin
      check("st_valid", 64'(wx_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) check("st_wx", wx_out, mq[0]);
      check("st_ready", 64'(in_ready), 64'(mq.size() < 2));
      check("st_err", 64'(frame_err), 64'(err_exp));

      v    = ($urandom_range(0, 9) < 7);
      r    = ($urandom_range(0, 9) < 6);
      sp   = 4'($urandom);
      w    = 8'($urandom);
      roll = int'($urandom_range(0, 199));
      if (terms.size() == NT - BT) l = (roll >= 3);
      else l = (roll < 2);
      in_valid  = v;
      wx_ready  = r;
      in_spike  = sp;
      in_weight = w;
      in_last   = l;

      acc     = v && (mq.size() < 2);
      pop     = r && (mq.size() > 0);
      err_exp = 1'b0;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        for (int i = 0; i < BT; i++) terms.push_back(sp[i] ? w[2*i +: 2] : 2'b00);
        if (l && terms.size() == NT) begin
          f = '0;
          for (int t = 0; t < NT; t++) f[2*t +: 2] = terms[t];
          mq.push_back(f);
          terms.delete();
          frames_done++;
        end else if (l || terms.size() == NT) begin
          err_exp = 1'b1;
          terms.delete();
        end
      end
      @(negedge clk);
      cycles++;
    end
    check("st_frames_done", 64'(frames_done), 64'(1000));
    in_valid = 1'b0;
    wx_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
